// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory line type plus the memory-port arbiter's state and owner enums.
package lc3b_types;

  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant policy for the memory-port arbiter; D wins ties unless
// MEM_ARB_ROUND_ROBIN_EN is defined, in which case the side that did not own last wins.
module mem_arb_pick
  import lc3b_types::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_owner_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_owner_i == OWN_D) begin
        grant_i_o = 1'b1;
      end else begin
        grant_d_o = 1'b1;
      end
`else
      // D is the older instruction in the pipeline, so it goes first.
      grant_d_o = 1'b1;
`endif
    end else begin
      grant_i_o = i_req_i;
      grant_d_o = d_req_i;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between I-cache and D-cache; grants, latches the command,
// routes mem_resp to the owner. MEM_ARB_ROUND_ROBIN_EN enables alternating tie-break.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds read/write high until its *_resp pulses for one
  // cycle; mem_read/mem_write stay high from grant until the edge where mem_resp=1.

  mem_arb_state_t    state_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic last_owner;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_arb_owner_t last_owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_D;
    end else if (state_q == IDLE && (grant_i || grant_d)) begin
      last_owner_q <= grant_d ? OWN_D : OWN_I;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_D;
`endif

  mem_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_owner_i (last_owner),
    .grant_i_o    (grant_i),
    .grant_d_o    (grant_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write from D is resolved as a write.
            state_q       <= BUSY_D;
            mem_write_q   <= d_write;
            mem_read_q    <= d_read & ~d_write;
            mem_address_q <= d_address;
            mem_wdata_q   <= d_wdata;
          end else if (grant_i) begin
            state_q       <= BUSY_I;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_address_q <= i_address;
          end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // A mem_resp seen in IDLE belongs to nobody and is dropped here.
  assign i_resp  = (state_q == BUSY_I) && mem_resp;
  assign d_resp  = (state_q == BUSY_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign dbg_state = state_q;

  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (reset) !(d_read && d_write))
    else $warning("mem_port_arbiter: d_read and d_write both high, handled as write");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, and a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import lc3b_types::*;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic [1:0]        dbg_state;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read   = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- checkers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkl(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              is_d;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    int                lat;
    logic              exp_rd;
    logic              exp_wr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k, input vec_t v);
    i_address = v.addr;
    d_address = v.addr;
    d_wdata   = v.wdata;
    i_read    = !v.is_d && v.rd;
    d_read    = v.is_d && v.rd;
    d_write   = v.is_d && v.wr;
    tick();
    chk1($sformatf("vec%0d mem_read", k), mem_read, v.exp_rd);
    chk1($sformatf("vec%0d mem_write", k), mem_write, v.exp_wr);
    chka($sformatf("vec%0d mem_address", k), mem_address, v.addr);
    if (v.exp_wr) chkl($sformatf("vec%0d mem_wdata", k), mem_wdata, v.wdata);
    for (int w = 1; w < v.lat; w++) begin
      tick();
      chk1($sformatf("vec%0d early resp", k), i_resp | d_resp, 1'b0);
      chka($sformatf("vec%0d addr hold", k), mem_address, v.addr);
    end
    mem_rdata = v.rdata;
    mem_resp  = 1'b1;
    #1;
    chk1($sformatf("vec%0d i_resp", k), i_resp, !v.is_d);
    chk1($sformatf("vec%0d d_resp", k), d_resp, v.is_d);
    if (v.is_d) chkl($sformatf("vec%0d d_rdata", k), d_rdata, v.rdata);
    else        chkl($sformatf("vec%0d i_rdata", k), i_rdata, v.rdata);
    tick();
    idle_inputs();
    #1;
    chk1($sformatf("vec%0d rd clear", k), mem_read, 1'b0);
    chk1($sformatf("vec%0d wr clear", k), mem_write, 1'b0);
    chk1($sformatf("vec%0d resp clear", k), i_resp | d_resp, 1'b0);
  endtask

  // ---------------- random run with reference model ----------------
  task automatic random_run(input int cycles);
    logic              m_busy, m_own, m_rd, m_wr, m_last, win;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic              i_act, d_act, i_drop, d_drop, d_wr;
    logic              e_ir, e_dr, ip, dp;
    int                mem_cnt, mem_lat;
    m_busy = 1'b0; m_own = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_last = 1'b1;
    m_addr = '0; m_wdata = '0;
    i_act = 1'b0; d_act = 1'b0; i_drop = 1'b0; d_drop = 1'b0; d_wr = 1'b0;
    mem_cnt = 0; mem_lat = $urandom_range(1, 4);
    for (int c = 0; c < cycles; c++) begin
      // memory side reacts to the command it sees
      if (mem_read || mem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          mem_cnt   = 0;
          mem_lat   = $urandom_range(1, 4);
        end else begin
          mem_resp = 1'b0;
        end
      end else begin
        mem_cnt   = 0;
        mem_resp  = ($urandom_range(0, 7) == 0);
        mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      // requesters
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1; i_drop = 1'b0;
        i_address = 16'($urandom());
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; d_drop = 1'b0;
        d_wr = 1'($urandom_range(0, 1));
        d_address = 16'($urandom());
        d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (m_busy && m_own && $urandom_range(0, 4) == 0) begin
        d_address = 16'($urandom());
        d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (m_busy && !m_own && $urandom_range(0, 4) == 0) i_address = 16'($urandom());
      if (m_busy && m_own && $urandom_range(0, 15) == 0) d_drop = 1'b1;
      if (m_busy && !m_own && $urandom_range(0, 15) == 0) i_drop = 1'b1;
      i_read  = i_act && !i_drop;
      d_read  = d_act && !d_drop && !d_wr;
      d_write = d_act && !d_drop && d_wr;

      @(negedge clk);
      e_ir = m_busy && !m_own && mem_resp;
      e_dr = m_busy && m_own && mem_resp;
      chk1("rnd i_resp", i_resp, e_ir);
      chk1("rnd d_resp", d_resp, e_dr);
      if (e_ir) chkl("rnd i_rdata", i_rdata, mem_rdata);
      if (e_dr) chkl("rnd d_rdata", d_rdata, mem_rdata);
      chk1("rnd mem_read", mem_read, m_busy && m_rd);
      chk1("rnd mem_write", mem_write, m_busy && m_wr);
      if (m_busy) chka("rnd mem_address", mem_address, m_addr);
      if (m_busy && m_wr) chkl("rnd mem_wdata", mem_wdata, m_wdata);

      // model: one transaction at a time, completion frees the port for the next edge
      if (m_busy) begin
        if (mem_resp) begin
          m_busy = 1'b0;
          if (m_own) begin d_act = 1'b0; d_drop = 1'b0; end
          else       begin i_act = 1'b0; i_drop = 1'b0; end
        end
      end else begin
        ip = i_read;
        dp = d_read || d_write;
        if (ip || dp) begin
          if (ip && dp) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = !m_last;
`else
            win = 1'b1;
`endif
          end else begin
            win = dp;
          end
          m_busy = 1'b1;
          m_own  = win;
          m_last = win;
          if (win) begin
            m_wr = d_write; m_rd = !d_write; m_addr = d_address; m_wdata = d_wdata;
          end else begin
            m_rd = 1'b1; m_wr = 1'b0; m_addr = i_address;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LINE_W-1:0] w;
    reset = 1'b1;
    idle_inputs();
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    chk1("reset mem_read", mem_read, 1'b0);
    chk1("reset mem_write", mem_write, 1'b0);
    chka("reset mem_address", mem_address, '0);
    chkl("reset mem_wdata", mem_wdata, '0);
    chk1("reset i_resp", i_resp, 1'b0);
    chk1("reset d_resp", d_resp, 1'b0);
    chk1("reset state idle", dbg_state == IDLE, 1'b1);
    do_reset();

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, 128'h0,
                128'hDEAD0000_00000000_00000000_0000BEEF, 3, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0100, 128'h0,
                128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h8000, 128'hCAFEF00D_11112222_33334444_55556666,
                128'h0, 2, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'hFFF0, 128'h0,
                128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 4, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0010, 128'h77777777_88888888_99999999_AAAAAAAA,
                128'h0, 2, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0000, {LINE_W{1'b1}},
                128'h0, 1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // reset while D write is in flight
    do_reset();
    d_write = 1'b1; d_address = 16'h4444; d_wdata = 128'h1;
    tick();
    chk1("rstmid pre mem_write", mem_write, 1'b1);
    reset = 1'b1;
    d_write = 1'b0;
    #1;
    chk1("rstmid mem_write", mem_write, 1'b0);
    chk1("rstmid mem_read", mem_read, 1'b0);
    chka("rstmid mem_address", mem_address, '0);
    chkl("rstmid mem_wdata", mem_wdata, '0);
    chk1("rstmid d_resp", d_resp, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk1("rstmid late d_resp", d_resp, 1'b0);
    chk1("rstmid late i_resp", i_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    chk1("rstmid idle write", mem_write, 1'b0);

    // address change while BUSY_D is ignored
    d_read = 1'b1; d_address = 16'h0100;
    tick();
    chka("addrchg grant", mem_address, 16'h0100);
    d_address = 16'h0200;
    repeat (2) begin
      tick();
      chka("addrchg hold", mem_address, 16'h0100);
      chk1("addrchg no resp", d_resp, 1'b0);
    end
    mem_resp = 1'b1;
    #1;
    chk1("addrchg d_resp", d_resp, 1'b1);
    chka("addrchg at resp", mem_address, 16'h0100);
    tick();
    idle_inputs();
    #1;
    chk1("addrchg done", mem_read, 1'b0);

    // simultaneous I read and D write
    do_reset();
    w = 128'hFEEDFACE_00000000_12345678_9ABCDEF0;
    i_read = 1'b1; i_address = 16'h0040;
    d_write = 1'b1; d_address = 16'h8000; d_wdata = w;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int g = 0; g < 4; g++) begin
      tick();
      chk1($sformatf("rr%0d mem_read", g), mem_read, (g % 2) == 0);
      chk1($sformatf("rr%0d mem_write", g), mem_write, (g % 2) == 1);
      chka($sformatf("rr%0d addr", g), mem_address, ((g % 2) == 0) ? 16'h0040 : 16'h8000);
      tick();
      mem_resp = 1'b1;
      #1;
      chk1($sformatf("rr%0d i_resp", g), i_resp, (g % 2) == 0);
      chk1($sformatf("rr%0d d_resp", g), d_resp, (g % 2) == 1);
      tick();
      mem_resp = 1'b0;
      #1;
      chk1($sformatf("rr%0d idle gap", g), mem_read | mem_write, 1'b0);
    end
`else
    tick();
    chk1("both d first write", mem_write, 1'b1);
    chk1("both d first read", mem_read, 1'b0);
    chka("both d addr", mem_address, 16'h8000);
    chkl("both d wdata", mem_wdata, w);
    tick();
    mem_resp = 1'b1;
    #1;
    chk1("both d_resp", d_resp, 1'b1);
    chk1("both i_resp quiet", i_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    d_write = 1'b0;
    #1;
    chk1("both idle gap", mem_read | mem_write, 1'b0);
    tick();
    chk1("both i read", mem_read, 1'b1);
    chka("both i addr", mem_address, 16'h0040);
    mem_resp = 1'b1;
    #1;
    chk1("both i_resp", i_resp, 1'b1);
    chk1("both d_resp quiet", d_resp, 1'b0);
    tick();
`endif
    idle_inputs();

    do_reset();
    random_run(3000);

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
